hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard sequencer for the 5-stage RISC-V core. It decides, every cycle, whether the front end advances, stalls for a load-use hazard, freezes for a multi-cycle MUL/DIV op in EX, or flushes IF/ID after a taken branch. It complements the EX-stage forwarding logic by covering the hazards forwarding cannot resolve. It also keeps stall and flush event counters for performance debug.

## Interface
- MDU_LATENCY, 4, number of cycles a MUL/DIV op occupies EX; legal 2..16.
- clk_i  input  1  core clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- IDrs1_i  input  5  rs1 of the instruction in ID.
- IDrs2_i  input  5  rs2 of the instruction in ID.
- EXMemRead_i  input  1  instruction in EX is a load.
- EXrd_i  input  5  rd of the instruction in EX.
- EXMdu_i  input  1  instruction in EX is a MUL/DIV op.
- Branch_i  input  1  branch resolved taken in ID this cycle.
- PCWrite_o  output  1  PC may update.
- IFIDWrite_o  output  1  IF/ID register may load.
- IFIDFlush_o  output  1  clear IF/ID to NOP.
- IDEXWrite_o  output  1  ID/EX register may load.
- IDEXBubble_o  output  1  load NOP into ID/EX.
- EXMEMBubble_o  output  1  load NOP into EX/MEM.
- MduStart_o  output  1  one-cycle start pulse to the MDU.
- MduDone_o  output  1  MDU result valid in EX this cycle.
- Busy_o  output  1  controller is in state MDU.
- StallCnt_o  output  32  count of stall cycles (load-use plus MDU).
- FlushCnt_o  output  32  count of IF/ID flushes.

## Operation
- The controller has two states, RUN and MDU, and a 5-bit down-counter `cnt`.
- **Defaults:** PCWrite_o, IFIDWrite_o and IDEXWrite_o are 1. All other 1-bit outputs are 0.
- **RUN with MDU start (highest priority):** condition is EXMdu_i=1.
  - MduStart_o=1.
  - Stall: PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0, EXMEMBubble_o=1.
  - cnt <= MDU_LATENCY-1; next state MDU.
  - Load-use and branch flush are suppressed this cycle.
- **RUN with load-use hazard:** condition is EXMemRead_i=1, EXrd_i!=0, and EXrd_i equals IDrs1_i or IDrs2_i.
  - PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1; IDEXWrite_o stays 1 so the bubble is written.
  - Branch flush is suppressed this cycle; the branch is re-evaluated next cycle.
- **RUN, otherwise:** IFIDFlush_o=Branch_i.
- **MDU state, cnt!=1:**
  - Same stall outputs as the MDU start cycle; Busy_o=1.
  - cnt <= cnt-1.
  - All other inputs are ignored.
- **MDU state, cnt==1:**
  - No stall; MduDone_o=1; Busy_o=1.
  - IFIDFlush_o=Branch_i.
  - Next state RUN.
  - EXMdu_i is ignored because it still reflects the same op.
- **EX occupancy:** a MUL/DIV op occupies EX for exactly MDU_LATENCY cycles, with MDU_LATENCY-1 stall cycles.
- **StallCnt_o** increments by 1 on every clock edge where PCWrite_o=0.
- **FlushCnt_o** increments by 1 on every edge where IFIDFlush_o=1.
- Both counters wrap modulo 2^32.
- **Illegal input:** EXMdu_i and EXMemRead_i both 1 cannot occur (one instruction in EX). If it does, MDU takes priority.
- **During reset:** while rst_i=1, all outputs take their default values and inputs are ignored.

## Timing
- All control outputs are combinational from the current state, `cnt` and the inputs, and are valid in the same cycle.
- state, `cnt` and both counters are registered.
- **Reset:** on an edge with rst_i=1 the block goes to state RUN with cnt=0, StallCnt_o=0 and FlushCnt_o=0.
- **Reset mid-MDU:** abandons the sequence. No MduDone_o is produced and Busy_o=0 from the next cycle.
- **MDU sequence:** MduStart_o at cycle T; stall cycles T..T+MDU_LATENCY-2; MduDone_o at T+MDU_LATENCY-1; Busy_o from T+1 to T+MDU_LATENCY-1.
- A new EXMdu_i is accepted in the first RUN cycle after MduDone_o, so back-to-back MDU ops are allowed.
- **Load-use stall:** exactly 1 cycle per hazard. If the hazard persists (a different load now in EX), the stall repeats.

## Test plan
- **Reset:** assert rst_i for 2 cycles with arbitrary inputs -> all outputs at defaults during reset; Busy_o=0, StallCnt_o=0, FlushCnt_o=0 after.
- **Load-use:** EXMemRead_i=1, EXrd_i=5, IDrs2_i=5 for one cycle -> PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1, then StallCnt_o=1. Repeat with EXrd_i=0 -> no stall.
- **MDU sequence (MDU_LATENCY=4):** EXMdu_i=1 held from T -> MduStart_o only at T; PCWrite_o=0 at T..T+2; MduDone_o=1 and PCWrite_o=1 at T+3; Busy_o=1 at T+1..T+3; StallCnt_o rises by 3.
- **Branch during MDU (MDU_LATENCY=4):** Branch_i=1 held from T+1 -> IFIDFlush_o=0 at T+1..T+2, 1 at T+3; FlushCnt_o=1.
- **Reset mid-MDU:** rst_i=1 at T+2 of the MDU sequence -> T+3 is in RUN, Busy_o=0, MduDone_o never asserted, StallCnt_o=0.
- **Load-use plus branch:** load-use hazard and Branch_i=1 in the same cycle -> stall, IFIDFlush_o=0. Next cycle with EXMemRead_i=0 and Branch_i=1 -> IFIDFlush_o=1.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, multi-cycle MUL/DIV freezes and
// IF/ID flushes on taken branches, plus stall/flush event counters.
module hazard_controller #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IDrs1_i,
    input  logic [4:0]  IDrs2_i,
    input  logic        EXMemRead_i,
    input  logic [4:0]  EXrd_i,
    input  logic        EXMdu_i,
    input  logic        Branch_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        EXMEMBubble_o,
    output logic        MduStart_o,
    output logic        MduDone_o,
    output logic        Busy_o,
    output logic [31:0] StallCnt_o,
    output logic [31:0] FlushCnt_o
);

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] MDU = 1'b1;
    localparam logic [4:0] MDU_LOAD = 5'(MDU_LATENCY - 1);

    logic [0:0] state;
    logic [0:0] stateNext;
    logic [4:0] cnt;
    logic [4:0] cntNext;
    logic       loadUse;

    assign loadUse = EXMemRead_i && (EXrd_i != 5'd0) &&
                     ((EXrd_i == IDrs1_i) || (EXrd_i == IDrs2_i));

    always_comb begin
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IDEXWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXBubble_o  = 1'b0;
        EXMEMBubble_o = 1'b0;
        MduStart_o    = 1'b0;
        MduDone_o     = 1'b0;
        Busy_o        = 1'b0;
        stateNext     = state;
        cntNext       = cnt;
        if (!rst_i) begin
            case (state)
                RUN: begin
                    if (EXMdu_i) begin
                        // MDU wins over load-use and branch, including the illegal load+MDU case
                        MduStart_o    = 1'b1;
                        PCWrite_o     = 1'b0;
                        IFIDWrite_o   = 1'b0;
                        IDEXWrite_o   = 1'b0;
                        EXMEMBubble_o = 1'b1;
                        cntNext       = MDU_LOAD;
                        stateNext     = MDU;
                    end else if (loadUse) begin
                        // ID/EX still loads so the bubble is written; branch retried next cycle
                        PCWrite_o    = 1'b0;
                        IFIDWrite_o  = 1'b0;
                        IDEXBubble_o = 1'b1;
                    end else begin
                        IFIDFlush_o = Branch_i;
                    end
                end
                default: begin
                    Busy_o = 1'b1;
                    if (cnt != 5'd1) begin
                        PCWrite_o     = 1'b0;
                        IFIDWrite_o   = 1'b0;
                        IDEXWrite_o   = 1'b0;
                        EXMEMBubble_o = 1'b1;
                        cntNext       = cnt - 5'd1;
                    end else begin
                        MduDone_o   = 1'b1;
                        IFIDFlush_o = Branch_i;
                        cntNext     = 5'd0;
                        stateNext   = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RUN;
            cnt        <= 5'd0;
            StallCnt_o <= 32'd0;
            FlushCnt_o <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (!PCWrite_o) StallCnt_o <= StallCnt_o + 32'd1;
            if (IFIDFlush_o) FlushCnt_o <= FlushCnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MDU_LATENCY=4) with hand-computed
// expectations; control outputs are packed into one 9-bit word for comparison.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        exMemRead, exMdu, branch;
    logic        pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble;
    logic        exmemBubble, mduStart, mduDone, busy;
    logic [31:0] stallCnt, flushCnt;

    int total = 0;
    int bad = 0;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, MduStart, MduDone, Busy}
    localparam logic [8:0] OUT_DEFAULT  = 9'b110100000;
    localparam logic [8:0] OUT_LOADUSE  = 9'b000110000;
    localparam logic [8:0] OUT_MDUSTART = 9'b000001100;
    localparam logic [8:0] OUT_MDUSTALL = 9'b000001001;
    localparam logic [8:0] OUT_MDUDONEF = 9'b111100011;
    localparam logic [8:0] OUT_FLUSH    = 9'b111100000;

    logic [8:0] outVec;
    assign outVec = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble,
                     exmemBubble, mduStart, mduDone, busy};

    hazard_controller #(.MDU_LATENCY(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .IDrs1_i(idRs1), .IDrs2_i(idRs2),
        .EXMemRead_i(exMemRead), .EXrd_i(exRd),
        .EXMdu_i(exMdu), .Branch_i(branch),
        .PCWrite_o(pcWrite), .IFIDWrite_o(ifidWrite), .IFIDFlush_o(ifidFlush),
        .IDEXWrite_o(idexWrite), .IDEXBubble_o(idexBubble),
        .EXMEMBubble_o(exmemBubble), .MduStart_o(mduStart), .MduDone_o(mduDone),
        .Busy_o(busy), .StallCnt_o(stallCnt), .FlushCnt_o(flushCnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic setIn(input logic [4:0] rs1, input logic [4:0] rs2, input logic memRd,
                         input logic [4:0] rd, input logic mdu, input logic br);
        idRs1 = rs1; idRs2 = rs2; exMemRead = memRd; exRd = rd; exMdu = mdu; branch = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with arbitrary inputs
        rst = 1'b1;
        setIn(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        #1 checkVal("rst_outs0", 32'(outVec), 32'(OUT_DEFAULT));
        tick();
        checkVal("rst_outs1", 32'(outVec), 32'(OUT_DEFAULT));
        tick();
        rst = 1'b0;
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkVal("post_rst_busy", 32'(busy), 32'd0);
        checkVal("post_rst_stall", stallCnt, 32'd0);
        checkVal("post_rst_flush", flushCnt, 32'd0);
        checkVal("idle_outs", 32'(outVec), 32'(OUT_DEFAULT));

        // load-use on rs2
        setIn(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        #1 checkVal("lu_rs2", 32'(outVec), 32'(OUT_LOADUSE));
        tick();
        checkVal("lu_stall1", stallCnt, 32'd1);
        // rd = x0 never hazards
        setIn(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 checkVal("lu_x0", 32'(outVec), 32'(OUT_DEFAULT));
        tick();
        checkVal("lu_x0_stall", stallCnt, 32'd1);
        // load-use on rs1, then a load not matching
        setIn(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0);
        #1 checkVal("lu_rs1", 32'(outVec), 32'(OUT_LOADUSE));
        tick();
        setIn(5'd7, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0);
        #1 checkVal("lu_nomatch", 32'(outVec), 32'(OUT_DEFAULT));
        checkVal("lu_stall2", stallCnt, 32'd2);
        tick();

        // MDU sequence, branch held from T+1
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1 checkVal("mdu_T", 32'(outVec), 32'(OUT_MDUSTART));
        tick();
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        #1 checkVal("mdu_T1", 32'(outVec), 32'(OUT_MDUSTALL));
        tick();
        checkVal("mdu_T2", 32'(outVec), 32'(OUT_MDUSTALL));
        tick();
        checkVal("mdu_T3", 32'(outVec), 32'(OUT_MDUDONEF));
        checkVal("mdu_T3_stall", stallCnt, 32'd5);
        checkVal("mdu_T3_flush", flushCnt, 32'd0);
        tick();
        // back-to-back MDU accepted immediately
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        checkVal("b2b_start", 32'(outVec), 32'(OUT_MDUSTART));
        checkVal("b2b_flush", flushCnt, 32'd1);
        checkVal("b2b_stall", stallCnt, 32'd5);
        tick();
        checkVal("b2b_T1", 32'(outVec), 32'(OUT_MDUSTALL));
        tick();
        // reset mid-MDU at T+2
        rst = 1'b1;
        #1 checkVal("midrst_outs", 32'(outVec), 32'(OUT_DEFAULT));
        tick();
        rst = 1'b0;
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkVal("midrst_T3_outs", 32'(outVec), 32'(OUT_DEFAULT));
        checkVal("midrst_busy", 32'(busy), 32'd0);
        checkVal("midrst_stall", stallCnt, 32'd0);
        tick();
        checkVal("midrst_T4_done", 32'(mduDone), 32'd0);

        // load-use plus branch: flush suppressed, then taken next cycle
        setIn(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1);
        #1 checkVal("lub_stall", 32'(outVec), 32'(OUT_LOADUSE));
        tick();
        checkVal("lub_flush0", flushCnt, 32'd0);
        setIn(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1);
        #1 checkVal("lub_flush", 32'(outVec), 32'(OUT_FLUSH));
        tick();
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checkVal("lub_flushcnt", flushCnt, 32'd1);
        checkVal("lub_stallcnt", stallCnt, 32'd1);

        // illegal load+MDU: MDU takes priority
        setIn(5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1);
        #1 checkVal("illegal_mdu", 32'(outVec), 32'(OUT_MDUSTART));
        tick();
        setIn(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 checkVal("illegal_busy", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
